// File: rtl/bcd_entry_to_bin_if.sv
// Digit-entry / conversion bus between a user-input source and bcd_entry_to_bin.
interface bcd_entry_to_bin_if #(
  parameter int unsigned N_DIGITS = 3,
  parameter int unsigned OUT_W    = 8
);
  logic [3:0]            digit_in;
  logic                  digit_valid;
  logic                  clear;
  logic                  start;
  logic [4*N_DIGITS-1:0] bcd_shadow;
  logic                  busy;
  logic                  done;
  logic [OUT_W-1:0]      bin_out;
  logic                  overflow;
  logic                  digit_error;

  modport master (
    output digit_in, digit_valid, clear, start,
    input  bcd_shadow, busy, done, bin_out, overflow, digit_error
  );

  modport slave (
    input  digit_in, digit_valid, clear, start,
    output bcd_shadow, busy, done, bin_out, overflow, digit_error
  );
endinterface

// File: rtl/bcd_entry_to_bin.sv
// Decimal digit entry register plus serial reverse double-dabble converter
// producing a saturated binary result.
module bcd_entry_to_bin #(
  parameter int unsigned N_DIGITS = 3,
  parameter int unsigned OUT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_entry_to_bin_if.slave bus
);
  localparam int unsigned BW = 4 * N_DIGITS;
  localparam int unsigned CW = $clog2(BW + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    shadow_q, shadow_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [BW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [OUT_W-1:0] bin_q, bin_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [BW-1:0]    bcd_shr;
  logic             busy_w;

  assign busy_w = (state_q != IDLE);

  // Next-state: digit entry, conversion FSM, clear override
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    bcd_d    = bcd_q;
    acc_d    = acc_q;
    count_d  = count_q;
    bin_d    = bin_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    err_d    = err_q;
    bcd_shr  = '0;

    if (bus.digit_valid && !busy_w) begin
      if (bus.digit_in <= 4'd9) begin
        // Oldest digit falls off the top when more than N_DIGITS are entered
        shadow_d = BW'({shadow_q, bus.digit_in});
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          bcd_d   = shadow_q;
          acc_d   = '0;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d   = {bcd_q[0], acc_q[BW-1:1]};
        bcd_shr = bcd_q >> 1;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
          if (bcd_shr[4*i +: 4] >= 4'd8) begin
            bcd_shr[4*i +: 4] = bcd_shr[4*i +: 4] - 4'd3;
          end
        end
        bcd_d   = bcd_shr;
        count_d = count_q + 1'b1;
        if (count_q == CW'(BW - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        if ((BW > OUT_W) && ((acc_q >> OUT_W) != '0)) begin
          bin_d = '1;
          ovf_d = 1'b1;
        end else begin
          bin_d = OUT_W'(acc_q);
          ovf_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything: results from an abandoned run are discarded
    if (bus.clear) begin
      shadow_d = '0;
      err_d    = 1'b0;
      state_d  = IDLE;
      done_d   = 1'b0;
      bin_d    = bin_q;
      ovf_d    = ovf_q;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      bcd_q    <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      bin_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      bcd_q    <= bcd_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      bin_q    <= bin_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.bcd_shadow  = shadow_q;
  assign bus.busy        = busy_w;
  assign bus.done        = done_q;
  assign bus.bin_out     = bin_q;
  assign bus.overflow    = ovf_q;
  assign bus.digit_error = err_q;
endmodule

// File: tb/tb_bcd_entry_to_bin.sv
// Directed self-checking bench for bcd_entry_to_bin.
module tb_bcd_entry_to_bin;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  bcd_entry_to_bin_if #(.N_DIGITS(3), .OUT_W(8)) bus ();

  bcd_entry_to_bin #(.N_DIGITS(3), .OUT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_digit(input logic [3:0] d);
    bus.digit_in    = d;
    bus.digit_valid = 1'b1;
    tick();
    bus.digit_valid = 1'b0;
    bus.digit_in    = 4'd0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  // Observes up to max_cyc cycles starting from the current one (index 0)
  task automatic wait_done(input int max_cyc, output int busy_cnt, output int done_cyc,
                           output int done_cnt, output logic busy_at_done);
    busy_cnt = 0; done_cyc = -1; done_cnt = 0; busy_at_done = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc     = i;
          busy_at_done = bus.busy;
        end
      end
      tick();
    end
  endtask

  task automatic run_conv(output int busy_cnt, output int done_cyc, output int done_cnt,
                          output logic busy_at_done);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(30, busy_cnt, done_cyc, done_cnt, busy_at_done);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    n_checks++;
    if (bus.bcd_shadow !== 12'h000 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.bin_out !== 8'h00 || bus.overflow !== 1'b0 || bus.digit_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: shadow=%h busy=%b done=%b bin=%h ovf=%b err=%b, required all 0",
               bus.bcd_shadow, bus.busy, bus.done, bus.bin_out, bus.overflow, bus.digit_error);
    end
  endtask

  task automatic test_max_in_range();
    int bc, dc, cnt; logic bad;
    enter_digit(4'd2); enter_digit(4'd5); enter_digit(4'd5);
    n_checks++;
    if (bus.bcd_shadow !== 12'h255) begin
      n_fail++; $display("FAIL entry_255: shadow=%h required 255", bus.bcd_shadow);
    end
    run_conv(bc, dc, cnt, bad);
    n_checks++;
    if (bc !== 13) begin n_fail++; $display("FAIL busy_len_255: got %0d required 13", bc); end
    n_checks++;
    if (dc !== 13) begin n_fail++; $display("FAIL done_time_255: got %0d required 13", dc); end
    n_checks++;
    if (cnt !== 1) begin n_fail++; $display("FAIL done_count_255: got %0d required 1", cnt); end
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL busy_at_done_255: got %b required 0", bad); end
    n_checks++;
    if (bus.bin_out !== 8'hFF || bus.overflow !== 1'b0 || bus.bcd_shadow !== 12'h255) begin
      n_fail++;
      $display("FAIL result_255: bin=%h ovf=%b shadow=%h required FF 0 255",
               bus.bin_out, bus.overflow, bus.bcd_shadow);
    end
  endtask

  task automatic test_overflow();
    int bc, dc, cnt; logic bad;
    enter_digit(4'd2); enter_digit(4'd5); enter_digit(4'd6);
    run_conv(bc, dc, cnt, bad);
    n_checks++;
    if (bus.bin_out !== 8'hFF || bus.overflow !== 1'b1 || cnt !== 1) begin
      n_fail++; $display("FAIL result_256: bin=%h ovf=%b done=%0d required FF 1 1", bus.bin_out, bus.overflow, cnt);
    end
    enter_digit(4'd9); enter_digit(4'd9); enter_digit(4'd9);
    run_conv(bc, dc, cnt, bad);
    n_checks++;
    if (bus.bin_out !== 8'hFF || bus.overflow !== 1'b1 || bus.bcd_shadow !== 12'h999) begin
      n_fail++; $display("FAIL result_999: bin=%h ovf=%b shadow=%h required FF 1 999",
                         bus.bin_out, bus.overflow, bus.bcd_shadow);
    end
    enter_digit(4'd0); enter_digit(4'd0); enter_digit(4'd0);
    run_conv(bc, dc, cnt, bad);
    n_checks++;
    if (bus.bin_out !== 8'h00 || bus.overflow !== 1'b0 || cnt !== 1) begin
      n_fail++; $display("FAIL result_000: bin=%h ovf=%b done=%0d required 00 0 1", bus.bin_out, bus.overflow, cnt);
    end
  endtask

  task automatic test_rollover();
    int bc, dc, cnt; logic bad;
    enter_digit(4'd1); enter_digit(4'd2); enter_digit(4'd3); enter_digit(4'd4);
    n_checks++;
    if (bus.bcd_shadow !== 12'h234) begin
      n_fail++; $display("FAIL rollover_shadow: shadow=%h required 234", bus.bcd_shadow);
    end
    run_conv(bc, dc, cnt, bad);
    n_checks++;
    if (bus.bin_out !== 8'hEA || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL result_234: bin=%h ovf=%b required EA 0", bus.bin_out, bus.overflow);
    end
    // start and digit strobe on the same edge: snapshot is 234, digit still entered
    bus.start = 1'b1; bus.digit_valid = 1'b1; bus.digit_in = 4'd7;
    tick();
    bus.start = 1'b0; bus.digit_valid = 1'b0; bus.digit_in = 4'd0;
    wait_done(30, bc, dc, cnt, bad);
    n_checks++;
    if (bus.bin_out !== 8'hEA || bus.overflow !== 1'b0 || dc !== 13) begin
      n_fail++; $display("FAIL start_with_digit: bin=%h ovf=%b done_at=%0d required EA 0 13",
                         bus.bin_out, bus.overflow, dc);
    end
    n_checks++;
    if (bus.bcd_shadow !== 12'h347) begin
      n_fail++; $display("FAIL start_with_digit_shadow: shadow=%h required 347", bus.bcd_shadow);
    end
  endtask

  task automatic test_digit_error();
    enter_digit(4'hA);
    n_checks++;
    if (bus.digit_error !== 1'b1 || bus.bcd_shadow !== 12'h347) begin
      n_fail++; $display("FAIL bad_digit: err=%b shadow=%h required 1 347", bus.digit_error, bus.bcd_shadow);
    end
    enter_digit(4'd5);
    n_checks++;
    if (bus.digit_error !== 1'b1 || bus.bcd_shadow !== 12'h475) begin
      n_fail++; $display("FAIL err_sticky: err=%b shadow=%h required 1 475", bus.digit_error, bus.bcd_shadow);
    end
    pulse_clear();
    n_checks++;
    if (bus.digit_error !== 1'b0 || bus.bcd_shadow !== 12'h000) begin
      n_fail++; $display("FAIL clear_entry: err=%b shadow=%h required 0 000", bus.digit_error, bus.bcd_shadow);
    end
  endtask

  task automatic test_clear_abort();
    int bc, dc, cnt; logic bad;
    enter_digit(4'd1); enter_digit(4'd0); enter_digit(4'd0);
    run_conv(bc, dc, cnt, bad);
    n_checks++;
    if (bus.bin_out !== 8'h64 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL result_100: bin=%h ovf=%b required 64 0", bus.bin_out, bus.overflow);
    end
    enter_digit(4'd0); enter_digit(4'd5); enter_digit(4'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick(); tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.bcd_shadow !== 12'h000) begin
      n_fail++; $display("FAIL clear_abort_idle: busy=%b shadow=%h required 0 000", bus.busy, bus.bcd_shadow);
    end
    wait_done(20, bc, dc, cnt, bad);
    n_checks++;
    if (cnt !== 0 || bus.bin_out !== 8'h64 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL clear_abort_result: done=%0d bin=%h ovf=%b required 0 64 0",
                         cnt, bus.bin_out, bus.overflow);
    end
  endtask

  task automatic test_reset_abort();
    int bc, dc, cnt; logic bad;
    enter_digit(4'd9); enter_digit(4'd9); enter_digit(4'd9);
    run_conv(bc, dc, cnt, bad);
    enter_digit(4'hB);
    enter_digit(4'd1); enter_digit(4'd2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick(); tick();
    rst_n = 1'b0; bus.digit_valid = 1'b1; bus.digit_in = 4'd3; bus.start = 1'b1;
    tick();
    rst_n = 1'b1; bus.digit_valid = 1'b0; bus.digit_in = 4'd0; bus.start = 1'b0;
    n_checks++;
    if (bus.bcd_shadow !== 12'h000 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.bin_out !== 8'h00 || bus.overflow !== 1'b0 || bus.digit_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort: shadow=%h busy=%b done=%b bin=%h ovf=%b err=%b, required all 0",
               bus.bcd_shadow, bus.busy, bus.done, bus.bin_out, bus.overflow, bus.digit_error);
    end
    wait_done(20, bc, dc, cnt, bad);
    n_checks++;
    if (cnt !== 0 || bc !== 0) begin
      n_fail++; $display("FAIL reset_abort_quiet: done=%0d busy=%0d required 0 0", cnt, bc);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cnt, done_cnt, first_done, second_done;
    enter_digit(4'd0); enter_digit(4'd4); enter_digit(4'd2);
    busy_cnt = 0; done_cnt = 0; first_done = -1; second_done = -1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (first_done < 0) first_done = i;
        else if (second_done < 0) second_done = i;
      end
      // noise while busy, then an immediate restart on the done cycle
      bus.start       = ((i >= 2 && i <= 6) || (bus.done && first_done == i)) ? 1'b1 : 1'b0;
      bus.digit_valid = (i >= 2 && i <= 6) ? 1'b1 : 1'b0;
      bus.digit_in    = 4'd7;
      tick();
    end
    bus.start = 1'b0; bus.digit_valid = 1'b0; bus.digit_in = 4'd0;
    n_checks++;
    if (first_done !== 13 || second_done !== 27 || done_cnt !== 2) begin
      n_fail++; $display("FAIL b2b_done: first=%0d second=%0d count=%0d required 13 27 2",
                         first_done, second_done, done_cnt);
    end
    n_checks++;
    if (busy_cnt !== 26) begin
      n_fail++; $display("FAIL b2b_busy: got %0d required 26", busy_cnt);
    end
    n_checks++;
    if (bus.bin_out !== 8'h2A || bus.overflow !== 1'b0 || bus.bcd_shadow !== 12'h042 ||
        bus.digit_error !== 1'b0) begin
      n_fail++; $display("FAIL b2b_result: bin=%h ovf=%b shadow=%h err=%b required 2A 0 042 0",
                         bus.bin_out, bus.overflow, bus.bcd_shadow, bus.digit_error);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n           = 1'b0;
    bus.digit_in    = 4'd0;
    bus.digit_valid = 1'b0;
    bus.clear       = 1'b0;
    bus.start       = 1'b0;
    test_reset();
    test_max_in_range();
    test_overflow();
    test_rollover();
    test_digit_error();
    test_clear_abort();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
